// File: rtl/io_input_ctrl.sv
// CPU input port: synchronizes and debounces a board button and captures the switch
// byte on a fresh press. The capture is zero- or sign-extended to 32 bits and handed
// to the CPU with a req/ack handshake.
module io_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  Switches,
    input  logic        Button,
    input  logic        req,
    input  logic        sign_ext,
    input  logic        ack,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        stall,
    output logic [7:0]  press_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARM        = 2'd1,
        WAIT_PRESS = 2'd2,
        VALID      = 2'd3
    } state_e;

    localparam logic [7:0] DB_TARGET = 8'(DEBOUNCE_CYCLES);

    // Synchronizers
    logic       btn_meta_q, btn_meta_d;
    logic       btn_sync_q, btn_sync_d;
    logic [7:0] sw_meta_q,  sw_meta_d;
    logic [7:0] sw_sync_q,  sw_sync_d;

    // Debouncer and edge detection
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       btn_db_q, btn_db_d;
    logic       btn_db_dly_q, btn_db_dly_d;
    logic       btn_rise_q, btn_rise_d;
    logic [7:0] press_count_q, press_count_d;

    // Request FSM and capture
    state_e      state_q, state_d;
    logic        sign_lat_q, sign_lat_d;
    logic [31:0] rd_data_q, rd_data_d;

    // NOTE: every variable gets a default at the top of an always_comb block, so no
    // path through the if/case logic can leave it unassigned and infer a latch.
    always_comb begin
        btn_meta_d = Button;
        btn_sync_d = btn_meta_q;
        sw_meta_d  = Switches;
        sw_sync_d  = sw_meta_q;

        cnt_inc  = cnt_q + 8'd1;
        cnt_d    = '0;
        btn_db_d = btn_db_q;
        if (btn_sync_q != btn_db_q) begin
            // Level flips (and the counter restarts) on the cycle the count would hit the target.
            if (cnt_inc == DB_TARGET) begin
                btn_db_d = ~btn_db_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end

        btn_db_dly_d  = btn_db_q;
        btn_rise_d    = btn_db_q & ~btn_db_dly_q;
        press_count_d = btn_rise_q ? press_count_q + 8'd1 : press_count_q;
    end

    always_comb begin
        state_d    = state_q;
        sign_lat_d = sign_lat_q;
        rd_data_d  = rd_data_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    sign_lat_d = sign_ext;
                    state_d    = ARM;
                end
            end
            ARM: begin
                // A press already held when the request arrived must be released first.
                if (!req) begin
                    state_d = IDLE;
                end else if (!btn_db_q) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // Abort is checked first so a coincident press is not captured.
                if (!req) begin
                    state_d = IDLE;
                end else if (btn_rise_q) begin
                    rd_data_d = sign_lat_q ? {{24{sw_sync_q[7]}}, sw_sync_q}
                                           : {24'b0, sw_sync_q};
                    state_d   = VALID;
                end
            end
            VALID: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the values from before the edge regardless of statement order.
    // NOTE: every register, synchronizers included, is cleared by the asynchronous reset
    // so a reset mid-request leaves no stale capture or half-counted press behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q    <= 1'b0;
            btn_sync_q    <= 1'b0;
            sw_meta_q     <= '0;
            sw_sync_q     <= '0;
            cnt_q         <= '0;
            btn_db_q      <= 1'b0;
            btn_db_dly_q  <= 1'b0;
            btn_rise_q    <= 1'b0;
            press_count_q <= '0;
            state_q       <= IDLE;
            sign_lat_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            btn_meta_q    <= btn_meta_d;
            btn_sync_q    <= btn_sync_d;
            sw_meta_q     <= sw_meta_d;
            sw_sync_q     <= sw_sync_d;
            cnt_q         <= cnt_d;
            btn_db_q      <= btn_db_d;
            btn_db_dly_q  <= btn_db_dly_d;
            btn_rise_q    <= btn_rise_d;
            press_count_q <= press_count_d;
            state_q       <= state_d;
            sign_lat_q    <= sign_lat_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = (state_q == VALID);
    assign stall       = req & ~rd_valid;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl: latency, zero/sign extension, glitch rejection,
// held-button arming, abort, press counter wrap and asynchronous reset in VALID.
module tb_io_input_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  Switches;
    logic        Button;
    logic        req;
    logic        sign_ext;
    logic        ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic [7:0]  press_count;

    int          vectors;
    int          miscompares;
    logic [7:0]  exp_cnt;

    io_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .Switches   (Switches),
        .Button     (Button),
        .req        (req),
        .sign_ext   (sign_ext),
        .ack        (ack),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .stall      (stall),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold);
        Button = 1'b1;
        tick(hold);
        Button = 1'b0;
        tick(hold);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (rd_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rd_valid), 32'd1);
    endtask

    task automatic handshake();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        req = 1'b0;
        Button = 1'b0;
        tick(10);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 8'd0;
        rst      = 1'b0;
        Switches = 8'h00;
        Button   = 1'b0;
        req      = 1'b0;
        sign_ext = 1'b0;
        ack      = 1'b0;

        // Reset state
        #1;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_press_count", 32'(press_count), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // Exact latency: 2 sync + 4 debounce + 1 edge + 1 capture
        Switches = 8'h15;
        sign_ext = 1'b0;
        req      = 1'b1;
        tick(3);
        check("lat_stall_waiting", 32'(stall), 32'd1);
        Button = 1'b1;
        tick(7);
        check("lat_not_yet_valid", 32'(rd_valid), 32'd0);
        tick(1);
        exp_cnt = exp_cnt + 8'd1;
        check("lat_valid", 32'(rd_valid), 32'd1);
        check("lat_rd_data", rd_data, 32'h0000_0015);
        check("lat_stall_released", 32'(stall), 32'd0);
        check("lat_press_count", 32'(press_count), 32'(exp_cnt));
        ack = 1'b1;
        tick(1);
        check("ack_drops_valid", 32'(rd_valid), 32'd0);
        ack = 1'b0;
        req = 1'b0;
        Button = 1'b0;
        tick(10);
        check("rd_data_holds", rd_data, 32'h0000_0015);

        // Sign extension, latched at acceptance even if sign_ext changes afterwards
        Switches = 8'hA5;
        sign_ext = 1'b1;
        req      = 1'b1;
        tick(1);
        sign_ext = 1'b0;
        tick(2);
        Button = 1'b1;
        wait_valid("sx_a5_timeout", 20);
        exp_cnt = exp_cnt + 8'd1;
        check("sx_a5_rd_data", rd_data, 32'hFFFF_FFA5);
        handshake();

        // Positive byte with sign extension; ack outside VALID is ignored
        Switches = 8'h6D;
        sign_ext = 1'b1;
        req      = 1'b1;
        tick(3);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("early_ack_ignored", 32'(stall), 32'd1);
        Button = 1'b1;
        wait_valid("sx_6d_timeout", 20);
        exp_cnt = exp_cnt + 8'd1;
        check("sx_6d_rd_data", rd_data, 32'h0000_006D);
        handshake();

        // Glitches shorter than the debounce window
        Switches = 8'h33;
        sign_ext = 1'b0;
        req      = 1'b1;
        tick(3);
        for (int g = 1; g <= 3; g++) begin
            Button = 1'b1;
            tick(g);
            Button = 1'b0;
            tick(8);
            check($sformatf("glitch%0d_press_count", g), 32'(press_count), 32'(exp_cnt));
            check($sformatf("glitch%0d_rd_valid", g), 32'(rd_valid), 32'd0);
            check($sformatf("glitch%0d_stall", g), 32'(stall), 32'd1);
        end
        req = 1'b0;
        tick(2);

        // Button already held when req rises: needs release and a fresh press
        Button = 1'b1;
        tick(10);
        exp_cnt = exp_cnt + 8'd1;
        check("held_press_count", 32'(press_count), 32'(exp_cnt));
        Switches = 8'h5A;
        req      = 1'b1;
        tick(10);
        check("held_no_capture", 32'(rd_valid), 32'd0);
        check("held_stall", 32'(stall), 32'd1);
        Button = 1'b0;
        tick(10);
        check("release_no_capture", 32'(rd_valid), 32'd0);
        Button = 1'b1;
        wait_valid("fresh_press_timeout", 20);
        exp_cnt = exp_cnt + 8'd1;
        check("fresh_rd_data", rd_data, 32'h0000_005A);
        check("fresh_press_count", 32'(press_count), 32'(exp_cnt));
        handshake();

        // req dropped on the very cycle btn_rise arrives: abort wins
        req = 1'b1;
        tick(3);
        Switches = 8'hC3;
        Button = 1'b1;
        tick(7);
        req = 1'b0;
        tick(1);
        exp_cnt = exp_cnt + 8'd1;
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_rd_data", rd_data, 32'h0000_005A);
        check("abort_stall", 32'(stall), 32'd0);
        Button = 1'b0;
        tick(10);
        check("abort_press_count", 32'(press_count), 32'(exp_cnt));
        check("abort_stays_idle", 32'(rd_valid), 32'd0);

        // 256 debounced presses wrap the counter back to the same value
        for (int p = 0; p < 256; p++) begin
            press(8);
        end
        check("wrap_press_count", 32'(press_count), 32'(exp_cnt));
        press(8);
        exp_cnt = exp_cnt + 8'd1;
        check("wrap_plus_one", 32'(press_count), 32'(exp_cnt));

        // Asynchronous reset while in VALID
        Switches = 8'h81;
        sign_ext = 1'b1;
        req      = 1'b1;
        tick(3);
        Button = 1'b1;
        wait_valid("pre_rst_timeout", 20);
        check("pre_rst_rd_data", rd_data, 32'hFFFF_FF81);
        Button = 1'b0;
        req    = 1'b0;
        tick(2);
        check("valid_ignores_req_drop", 32'(rd_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_rd_data", rd_data, 32'h0);
        check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("async_rst_press_count", 32'(press_count), 32'd0);
        check("async_rst_stall", 32'(stall), 32'd0);
        tick(2);
        rst = 1'b1;
        exp_cnt = 8'd0;
        tick(2);

        // CPU re-issues the request after reset
        Switches = 8'h7E;
        sign_ext = 1'b0;
        req      = 1'b1;
        tick(3);
        Button = 1'b1;
        wait_valid("reissue_timeout", 20);
        exp_cnt = exp_cnt + 8'd1;
        check("reissue_rd_data", rd_data, 32'h0000_007E);
        check("reissue_press_count", 32'(press_count), 32'(exp_cnt));
        handshake();
        check("reissue_done", 32'(rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_input_ctrl.md
IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable sampled cycles before the debounced button level changes (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Switches, input, 8, raw board switch value.
REQ-005 SHALL have port Button, input, 1, raw board confirm button, active-high, bouncy.
REQ-006 SHALL have port req, input, 1, CPU input request; level, held until ack handshake completes.
REQ-007 SHALL have port sign_ext, input, 1, 1 selects sign extension of the switch byte; sampled when a request is accepted.
REQ-008 SHALL have port ack, input, 1, CPU accepts rd_data.
REQ-009 SHALL have port rd_data, output, 32, captured switch value, extended to 32 bits.
REQ-010 SHALL have port rd_valid, output, 1, rd_data valid.
REQ-011 SHALL have port stall, output, 1, CPU must hold the current instruction.
REQ-012 SHALL have port press_count, output, 8, count of debounced button presses.

Function
REQ-013 SHALL pass Button and Switches through 2-flop synchronizers before any use.
REQ-014 SHALL keep debounced level btn_db and a counter; counter clears when synced Button equals btn_db, else increments; btn_db toggles and counter clears on the cycle the counter would reach DEBOUNCE_CYCLES.
REQ-015 SHALL generate btn_rise, a registered one-cycle pulse when btn_db goes 0->1; press_count increments on each btn_rise and wraps 255->0.
REQ-016 SHALL implement FSM states IDLE, ARM, WAIT_PRESS, VALID.
REQ-017 IDLE: on req=1 latch sign_ext, go ARM; btn_rise ignored.
REQ-018 ARM: if btn_db=0 go WAIT_PRESS; else remain (a press held before the request must be released first).
REQ-019 WAIT_PRESS: on btn_rise capture synchronized Switches, extended per latched sign_ext (zero: {24'b0,sw}; sign: {24{sw[7]},sw}), into rd_data; go VALID.
REQ-020 VALID: rd_valid=1; on ack=1 go IDLE and drop rd_valid next cycle; rd_data holds its value until the next capture.
REQ-021 req=0 in ARM or WAIT_PRESS SHALL abort to IDLE without changing rd_data.
REQ-022 ack while not in VALID SHALL be ignored; req changes while in VALID SHALL be ignored.
REQ-023 btn_rise coinciding with req=0 in WAIT_PRESS: abort wins, no capture.
REQ-024 stall SHALL equal req AND NOT rd_valid (combinational).
REQ-025 Minimum latency from stable Button 0->1 to rd_valid=1: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge register) + 1 (capture) cycles.

Reset
REQ-026 On rst=0, immediately and regardless of state: FSM IDLE, rd_data 0, rd_valid 0, press_count 0, btn_db 0, counter 0, synchronizers 0, latched sign_ext 0.
REQ-027 Reset asserted mid-request SHALL discard the request; after release the CPU re-issues req.

Verification
REQ-028 Switches=8'h15, sign_ext=0, req=1, clean press -> rd_valid=1 with rd_data=32'h00000015 exactly REQ-025 latency after Button rises; ack -> rd_valid=0 next cycle.
REQ-029 Switches=8'hA5, sign_ext=1 -> rd_data=32'hFFFFFFA5; Switches=8'h6D, sign_ext=1 -> rd_data=32'h0000006D.
REQ-030 Button glitches of 1..DEBOUNCE_CYCLES-1 cycles -> no btn_rise, press_count unchanged, rd_valid stays 0, stall=1.
REQ-031 Button already held when req rises -> no capture until release and fresh press; press_count increments once per debounced press, 256 presses wrap to 0.
REQ-032 req dropped in WAIT_PRESS, then press -> state IDLE, rd_valid 0, rd_data keeps prior value; rst=0 pulse while in VALID -> all outputs 0 asynchronously.
